// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Handshaked, registered ALU. Single-cycle ops (logic, add/sub, compare,
//   shifts) produce a registered result one clock after accept. Unsigned
//   MUL/MULH runs as a WIDTH-cycle shift-add sequence. A pending result is
//   held stable until the consumer takes it, and that backpressure reaches
//   issue through ready_o.
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         synchronous, active-high reset
//   valid_i       rs_i / rt_i / opcode_i are valid
//   ready_o       block accepts an op this cycle (combinational)
//   rs_i          operand A
//   rt_i          operand B; low SHAMT_W bits are the shift amount
//   opcode_i      operation select (1010..1111 are illegal)
//   valid_o       result registers hold an unconsumed result
//   ready_i       consumer takes the result
//   alu_result_o  registered result
//   zero_o        registered result is zero
//   carry_o       ADD carry-out / SUB borrow, else 0
//   overflow_o    signed overflow for ADD/SUB, else 0
//   illegal_o     opcode was unassigned
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic [3:0]       opcode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] alu_result_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             illegal_o
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = SHAMT_W + 1;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_NOT  = 4'b0011,
        OP_SUB  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_SLL  = 4'b0110,
        OP_SRL  = 4'b0111,
        OP_MUL  = 4'b1000,
        OP_MULH = 4'b1001
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e state_q, state_d;
    logic   accept;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH:0]       add_w;
    logic [WIDTH-1:0]     sub_w;
    logic [SHAMT_W-1:0]   shamt;
    logic [WIDTH-1:0]     op_res;
    logic                 op_carry, op_ovf, op_ill, op_mul;

    assign add_w = {1'b0, rs_i} + {1'b0, rt_i};
    assign sub_w = rs_i - rt_i;
    assign shamt = rt_i[SHAMT_W-1:0];

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        op_ovf   = 1'b0;
        op_ill   = 1'b0;
        op_mul   = 1'b0;
        case (opcode_i)
            OP_AND: op_res = rs_i & rt_i;
            OP_OR:  op_res = rs_i | rt_i;
            OP_ADD: begin
                op_res   = add_w[WIDTH-1:0];
                op_carry = add_w[WIDTH];
                op_ovf   = (rs_i[WIDTH-1] == rt_i[WIDTH-1]) &&
                           (add_w[WIDTH-1] != rs_i[WIDTH-1]);
            end
            OP_NOT: op_res = ~rs_i;
            OP_SUB: begin
                op_res   = sub_w;
                op_carry = (rs_i < rt_i);  // borrow
                op_ovf   = (rs_i[WIDTH-1] != rt_i[WIDTH-1]) &&
                           (sub_w[WIDTH-1] != rs_i[WIDTH-1]);
            end
            OP_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(rs_i) < $signed(rt_i))};
            OP_SLL: op_res = rs_i << shamt;
            OP_SRL: op_res = rs_i >> shamt;
            OP_MUL, OP_MULH: op_mul = 1'b1;
            default: op_ill = 1'b1;
        endcase
    end

    // ---------------- shift-add multiplier ----------------
    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_step;
    logic [WIDTH-1:0]   mplier_q, mul_res;
    logic [CNT_W-1:0]   count_q;
    logic               mulh_q, mul_last;

    // Accumulator value after this cycle's conditional add; the final result
    // is taken from it so the last partial product is not lost.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last = (count_q == CNT_W'(1));
    assign mul_res  = mulh_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];

    // ---------------- control ----------------
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        case (state_q)
            S_IDLE: ready_o = 1'b1;
            S_BUSY: ready_o = 1'b0;
            S_DONE: ready_o = ready_i;  // a new op can replace a result being consumed
            default: ready_o = 1'b0;
        endcase

        case (state_q)
            S_IDLE: if (valid_i) state_d = op_mul ? S_BUSY : S_DONE;
            S_BUSY: if (mul_last) state_d = S_DONE;
            S_DONE: begin
                if (ready_i && valid_i) state_d = op_mul ? S_BUSY : S_DONE;
                else if (ready_i)       state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign accept  = valid_i & ready_o;
    assign valid_o = (state_q == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            alu_result_o <= '0;
            zero_o       <= 1'b0;
            carry_o      <= 1'b0;
            overflow_o   <= 1'b0;
            illegal_o    <= 1'b0;
            mcand_q      <= '0;
            acc_q        <= '0;
            mplier_q     <= '0;
            count_q      <= '0;
            mulh_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (op_mul) begin
                    mcand_q  <= {{WIDTH{1'b0}}, rs_i};
                    mplier_q <= rt_i;
                    acc_q    <= '0;
                    count_q  <= CNT_W'(WIDTH);
                    mulh_q   <= (opcode_i == OP_MULH);
                end else begin
                    alu_result_o <= op_res;
                    zero_o       <= (op_res == '0);
                    carry_o      <= op_carry;
                    overflow_o   <= op_ovf;
                    illegal_o    <= op_ill;
                end
            end else if (state_q == S_BUSY) begin
                acc_q    <= acc_step;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                count_q  <= count_q - CNT_W'(1);
                if (mul_last) begin
                    alu_result_o <= mul_res;
                    zero_o       <= (mul_res == '0);
                    carry_o      <= 1'b0;
                    overflow_o   <= 1'b0;
                    illegal_o    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//   Directed bench for seq_alu (WIDTH = 8). Stimulus pushes hand-computed
//   expected results into a scoreboard queue; an independent monitor pops and
//   compares whenever a result is consumed (valid_o & ready_i).
// -----------------------------------------------------------------------------
module tb_seq_alu;

    localparam int W = 8;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_NOT  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_MULH = 4'b1001;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] rs_i;
    logic [W-1:0] rt_i;
    logic [3:0]   opcode_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] alu_result_o;
    logic         zero_o, carry_o, overflow_o, illegal_o;

    seq_alu #(.WIDTH(W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .rs_i         (rs_i),
        .rt_i         (rt_i),
        .opcode_i     (opcode_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .alu_result_o (alu_result_o),
        .zero_o       (zero_o),
        .carry_o      (carry_o),
        .overflow_o   (overflow_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        logic         ill;
    } exp_t;

    exp_t scb[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_push = 0;
    int   n_pop  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] res, input logic z, input logic c,
                                input logic v, input logic ill);
        exp_t e;
        e.res = res; e.z = z; e.c = c; e.v = v; e.ill = ill;
        return e;
    endfunction

    function automatic logic [3:0] flags();
        return {zero_o, carry_o, overflow_o, illegal_o};
    endfunction

    // Present an op, wait (bounded) until it is accepted, record its expected
    // response. valid_i is left high so callers can issue back to back.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e);
        bit ok = 0;
        valid_i  = 1'b1;
        opcode_i = op;
        rs_i     = a;
        rt_i     = b;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk_i);
            if (ready_o) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: op %0h never accepted", op);
            valid_i = 1'b0;
        end else begin
            @(posedge clk_i);
            scb.push_back(e);
            n_push++;
            #1;
        end
    endtask

    // Monitor: one comparison set per consumed result.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i === 1'b0 && valid_o === 1'b1 && ready_i === 1'b1) begin
                if (scb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got 0x%0h with empty scoreboard", alu_result_o);
                end else begin
                    mon_e = scb.pop_front();
                    n_pop++;
                    check("result", 32'(alu_result_o), 32'(mon_e.res));
                    check("flags_zcvi", 32'(flags()), 32'({mon_e.z, mon_e.c, mon_e.v, mon_e.ill}));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        rs_i     = '0;
        rt_i     = '0;
        opcode_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset state
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_ready_o", 32'(ready_o), 32'd1);
        check("rst_result",  32'(alu_result_o), 32'h0);
        check("rst_flags",   32'(flags()), 32'h0);

        // AND with single-cycle latency check
        send(OP_AND, 8'h55, 8'hAA, mk(8'h00, 1, 0, 0, 0));
        valid_i = 1'b0;
        check("and_valid_after_1", 32'(valid_o), 32'd1);
        @(posedge clk_i); #1;

        // Single-cycle ops back to back
        send(OP_ADD, 8'h7F, 8'h01, mk(8'h80, 0, 0, 1, 0));
        send(OP_ADD, 8'hFF, 8'h01, mk(8'h00, 1, 1, 0, 0));
        send(OP_SUB, 8'h05, 8'h02, mk(8'h03, 0, 0, 0, 0));
        send(OP_SUB, 8'h02, 8'h05, mk(8'hFD, 0, 1, 0, 0));
        send(OP_SLT, 8'hFE, 8'h01, mk(8'h01, 0, 0, 0, 0));
        send(OP_SLL, 8'h01, 8'h0B, mk(8'h08, 0, 0, 0, 0));
        send(OP_SRL, 8'h80, 8'h07, mk(8'h01, 0, 0, 0, 0));
        send(OP_NOT, 8'hFE, 8'h00, mk(8'h01, 0, 0, 0, 0));
        send(4'b1111, 8'h12, 8'h34, mk(8'h00, 1, 0, 0, 1));
        valid_i = 1'b0;
        @(posedge clk_i); #1;

        // MUL: 8 busy cycles, valid 8 cycles after accept
        send(OP_MUL, 8'h0F, 8'h11, mk(8'hFF, 0, 0, 0, 0));
        valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("mul_busy_ready_o", 32'(ready_o), 32'd0);
            check("mul_busy_valid_o", 32'(valid_o), 32'd0);
            @(posedge clk_i); #1;
        end
        check("mul_valid_after_8", 32'(valid_o), 32'd1);

        send(OP_MULH, 8'hFF, 8'hFF, mk(8'hFE, 0, 0, 0, 0));
        valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("mulh_busy_ready_o", 32'(ready_o), 32'd0);
            @(posedge clk_i); #1;
        end
        check("mulh_valid_after_8", 32'(valid_o), 32'd1);
        @(posedge clk_i); #1;

        // Backpressure: pending result held for 3 cycles
        ready_i = 1'b0;
        send(OP_ADD, 8'h10, 8'h20, mk(8'h30, 0, 0, 0, 0));
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid_o", 32'(valid_o), 32'd1);
            check("bp_ready_o", 32'(ready_o), 32'd0);
            check("bp_result",  32'(alu_result_o), 32'h30);
            check("bp_flags",   32'(flags()), 32'h0);
            @(posedge clk_i); #1;
        end
        ready_i = 1'b1;
        send(OP_ADD, 8'h01, 8'h02, mk(8'h03, 0, 0, 0, 0));
        send(OP_ADD, 8'h03, 8'h04, mk(8'h07, 0, 0, 0, 0));
        send(OP_ADD, 8'h80, 8'h80, mk(8'h00, 1, 1, 1, 0));
        send(OP_ADD, 8'h7F, 8'h7F, mk(8'hFE, 0, 0, 1, 0));
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("b2b_no_drop_dup", 32'(n_pop), 32'(n_push));

        // Reset in the 4th busy cycle of a MUL aborts it
        send(OP_MUL, 8'h03, 8'h05, mk(8'h0F, 0, 0, 0, 0));
        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        void'(scb.pop_back());
        n_push--;
        check("abort_valid_o", 32'(valid_o), 32'd0);
        check("abort_ready_o", 32'(ready_o), 32'd1);
        check("abort_result",  32'(alu_result_o), 32'h0);
        check("abort_flags",   32'(flags()), 32'h0);

        send(OP_OR, 8'h0F, 8'hF0, mk(8'hFF, 0, 0, 0, 0));
        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("final_all_consumed", 32'(n_pop), 32'(n_push));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the 8-bit combinational ALU in the datapath. It takes `rs_i`/`rt_i`/`opcode_i` through a valid/ready input port and registers its result and flags. Single-cycle ops complete in one clock; unsigned multiply runs as a WIDTH-cycle shift-add sequence. The block sits between register-file read and writeback, so downstream stalls propagate back to issue through `ready_o`.

## Interface

- WIDTH, 8, datapath width; a power of two ≥ 4. SHAMT_W = $clog2(WIDTH) is derived internally.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  operands/opcode valid.
- ready_o  out  1  block can accept this cycle.
- rs_i  in  WIDTH  operand A.
- rt_i  in  WIDTH  operand B (shift amount for shifts).
- opcode_i  in  4  operation select.
- valid_o  out  1  result registers hold an unconsumed result.
- ready_i  in  1  consumer accepts result.
- alu_result_o  out  WIDTH  result.
- zero_o  out  1  alu_result_o == 0.
- carry_o  out  1  ADD carry-out; SUB borrow (rs < rt unsigned); 0 otherwise.
- overflow_o  out  1  signed overflow for ADD/SUB; 0 otherwise.
- illegal_o  out  1  opcode was unassigned.

## Operation

Opcodes:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 NOT rs
- 0100 SUB (rs − rt)
- 0101 SLT: signed rs < rt, giving 1 or 0 zero-extended.
- 0110 SLL: rs << rt[SHAMT_W-1:0]
- 0111 SRL: logical, same shift amount.
- 1000 MUL: low WIDTH bits of the unsigned product.
- 1001 MULH: high WIDTH bits of the unsigned product.
- 1010–1111 illegal: result 0, zero_o 1, illegal_o 1.

General rules:
- Arithmetic is modulo 2^WIDTH.
- Upper bits of rt beyond SHAMT_W are ignored for shifts.

FSM:
- IDLE: ready_o = 1. On accept (valid_i & ready_o):
  - Single-cycle opcode: compute, load output registers, go DONE.
  - MUL/MULH: load multiplicand, multiplier and 2·WIDTH accumulator (0), set count = WIDTH, go BUSY.
- BUSY: ready_o = 0. Each cycle:
  - Add the multiplicand to the accumulator if multiplier LSB = 1.
  - Shift the multiplicand left and the multiplier right.
  - Decrement count.
  - When count reaches 0 on this edge, load alu_result_o from the low or high half and go DONE.
- DONE: valid_o = 1, and ready_o = ready_i.
  - ready_i & valid_i: accept the new op in the same cycle (single-cycle op → stay DONE with new result; MUL → BUSY).
  - ready_i & !valid_i: → IDLE.
  - !ready_i: hold.

## Timing

- Reset (rst_i high at an edge):
  - State → IDLE, valid_o 0, alu_result_o 0, all flags 0.
  - Inputs are ignored while rst_i is high.
- ready_o is combinational from state and ready_i. It is 1 in the first cycle after reset.
- Single-cycle op latency: accepted at edge t, so valid_o and the result are visible after edge t.
  - Throughput is one op per cycle while ready_i = 1.
- MUL/MULH latency: accepted at edge t, valid_o rises after edge t+WIDTH (WIDTH BUSY cycles).
- While valid_o & !ready_i, alu_result_o and all flags remain stable.
- Reset mid-BUSY aborts the multiply and no result is produced.
- Reset in DONE drops the pending result.
- zero_o is derived from the registered result for every opcode, including MUL/MULH.

## Test plan

All scenarios use WIDTH = 8.

- AND 0x55, 0xAA → result 0x00, zero_o 1; valid_o exactly one cycle after accept.
- ADD 0x7F + 0x01 → 0x80, overflow_o 1, carry_o 0. ADD 0xFF + 0x01 → 0x00, zero_o 1, carry_o 1. SUB 0x05 − 0x02 → 0x03, carry_o 0.
- SLT 0xFE, 0x01 → 0x01. SLL 0x01 by rt = 0x0B → 0x08 (upper rt bits ignored). NOT 0xFE → 0x01. Opcode 1111 → 0x00, illegal_o 1.
- MUL 0x0F × 0x11 → 0xFF. MULH 0xFF × 0xFF → 0xFE.
  - ready_o is 0 for 8 cycles.
  - valid_o rises exactly 8 cycles after accept.
- Backpressure: ready_i held 0 for 3 cycles with a result pending → outputs unchanged and ready_o 0. Then ready_i = 1 with back-to-back ADDs → one result per cycle, none dropped or duplicated.
- rst_i asserted in the 4th BUSY cycle of a MUL → next cycle valid_o 0, ready_o 1, outputs 0. A following OR 0x0F, 0xF0 → 0xFF.
